// File: rtl/alu_seq.sv
// alu_seq: registered ALU with a start/done handshake.
// Single-cycle ops finish on the accepting edge. Multiply uses shift-add and
// divide uses restoring division, one bit per cycle for WIDTH cycles.
module alu_seq #(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [3:0]       ALU_Sel,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] ALU_Out,
  output logic             CarryOut,
  output logic             ZeroOut,
  output logic             DivZero
);

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV} state_t;

  localparam logic [3:0] OP_MUL = 4'b1000;
  localparam logic [3:0] OP_DIV = 4'b1001;

  state_t state_q, state_d;

  // Result and flag registers
  logic [WIDTH-1:0] out_q;
  logic             carry_q, zero_q, dz_q, done_q;

  // Iteration state
  logic [SHW-1:0]     cnt_q;
  logic [2*WIDTH-1:0] mcand_q, prod_q;
  logic [WIDTH-1:0]   mplier_q;
  logic [WIDTH-1:0]   quo_q, dvsr_q, rem_q;

  logic accept, go_mul, go_div, go_single, last_iter;

  assign accept    = start && (state_q == S_IDLE);
  assign go_mul    = accept && (ALU_Sel == OP_MUL);
  // A divide by zero has a fixed answer, so it completes like a single-cycle op.
  assign go_div    = accept && (ALU_Sel == OP_DIV) && (B != '0);
  assign go_single = accept && !go_mul && !go_div;
  assign last_iter = (cnt_q == SHW'(WIDTH-1));

  // Single-cycle datapath, evaluated from the live inputs
  logic [WIDTH:0]   sum;
  logic [SHW-1:0]   shamt, rot_amt;
  logic             sh_big;
  logic [WIDTH-1:0] rotl, rotr;
  logic [WIDTH-1:0] s_res;
  logic             s_carry, s_dz;

  assign sum     = {1'b0, A} + {1'b0, B};
  assign shamt   = B[SHW-1:0];
  assign sh_big  = |(B >> SHW);
  // Rotate amount reduced modulo WIDTH so non-power-of-two widths stay correct.
  assign rot_amt = SHW'(32'(shamt) % WIDTH);
  // A zero rotate amount makes the wrap term shift by WIDTH, which yields zero.
  assign rotl    = (A << rot_amt) | (A >> (WIDTH - int'(rot_amt)));
  assign rotr    = (A >> rot_amt) | (A << (WIDTH - int'(rot_amt)));

  // Opcode decode for the single-cycle group
  always_comb begin
    s_res   = '0;
    s_carry = 1'b0;
    s_dz    = 1'b0;
    case (ALU_Sel)
      4'b0000: begin s_res = sum[WIDTH-1:0]; s_carry = sum[WIDTH]; end
      4'b0001: begin s_res = A - B; s_carry = (A >= B); end
      4'b0010: s_res = A & B;
      4'b0011: s_res = A | B;
      4'b0100: s_res = sh_big ? '0 : (A << shamt);
      4'b0101: s_res = sh_big ? '0 : (A >> shamt);
      4'b0110: s_res = rotl;
      4'b0111: s_res = rotr;
      4'b1001: begin s_res = '1; s_carry = 1'b1; s_dz = 1'b1; end
      4'b1010: s_res = A ^ B;
      4'b1011: s_res = ~(A | B);
      4'b1100: s_res = ~(A & B);
      4'b1101: s_res = ~(A ^ B);
      4'b1110: s_res = {{(WIDTH-1){1'b0}}, (A > B)};
      4'b1111: s_res = {{(WIDTH-1){1'b0}}, (A == B)};
      default: s_res = '0;
    endcase
  end

  // One multiply step and one restoring-divide step
  logic [2*WIDTH-1:0] prod_nxt;
  logic [WIDTH:0]     rem_sh;
  logic               q_bit;
  logic [WIDTH-1:0]   rem_nxt, quo_nxt;

  assign prod_nxt = mplier_q[0] ? (prod_q + mcand_q) : prod_q;
  assign rem_sh   = {rem_q, quo_q[WIDTH-1]};
  assign q_bit    = (rem_sh >= {1'b0, dvsr_q});
  // When the trial subtract succeeds the difference is below the divisor, so
  // WIDTH bits hold it exactly.
  assign rem_nxt  = q_bit ? (rem_sh[WIDTH-1:0] - dvsr_q) : rem_sh[WIDTH-1:0];
  assign quo_nxt  = {quo_q[WIDTH-2:0], q_bit};

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (go_mul)      state_d = S_MUL;
        else if (go_div) state_d = S_DIV;
      end
      S_MUL, S_DIV: if (last_iter) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // FSM outputs
  always_comb begin
    busy = (state_q != S_IDLE);
  end

  // Operand capture, iteration and result registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q    <= '0;
      carry_q  <= 1'b0;
      zero_q   <= 1'b1;
      dz_q     <= 1'b0;
      done_q   <= 1'b0;
      cnt_q    <= '0;
      mcand_q  <= '0;
      prod_q   <= '0;
      mplier_q <= '0;
      quo_q    <= '0;
      dvsr_q   <= '0;
      rem_q    <= '0;
    end else begin
      done_q <= 1'b0;
      if (go_single) begin
        out_q   <= s_res;
        carry_q <= s_carry;
        zero_q  <= (s_res == '0);
        dz_q    <= s_dz;
        done_q  <= 1'b1;
      end
      if (go_mul) begin
        mcand_q  <= {{WIDTH{1'b0}}, A};
        mplier_q <= B;
        prod_q   <= '0;
        cnt_q    <= '0;
      end
      if (go_div) begin
        quo_q  <= A;
        dvsr_q <= B;
        rem_q  <= '0;
        cnt_q  <= '0;
      end
      if (state_q == S_MUL) begin
        prod_q   <= prod_nxt;
        mcand_q  <= mcand_q << 1;
        mplier_q <= mplier_q >> 1;
        cnt_q    <= cnt_q + SHW'(1);
        if (last_iter) begin
          cnt_q   <= '0;
          out_q   <= prod_nxt[WIDTH-1:0];
          carry_q <= |prod_nxt[2*WIDTH-1:WIDTH];
          zero_q  <= (prod_nxt[WIDTH-1:0] == '0);
          dz_q    <= 1'b0;
          done_q  <= 1'b1;
        end
      end
      if (state_q == S_DIV) begin
        rem_q <= rem_nxt;
        quo_q <= quo_nxt;
        cnt_q <= cnt_q + SHW'(1);
        if (last_iter) begin
          cnt_q   <= '0;
          out_q   <= quo_nxt;
          carry_q <= 1'b0;
          zero_q  <= (quo_nxt == '0);
          dz_q    <= 1'b0;
          done_q  <= 1'b1;
        end
      end
    end
  end

  assign done     = done_q;
  assign ALU_Out  = out_q;
  assign CarryOut = carry_q;
  assign ZeroOut  = zero_q;
  assign DivZero  = dz_q;

endmodule
